cordic_atan_rom: RTL and testbench
==================================

Name: cordic_atan_rom

Overview:
- Constant lookup table for the iterative CORDIC datapath.
- Returns atan(2^-i) for iteration index i = 0..31 as a 32-bit fixed-point angle in radians.
- Sits beside the CORDIC iteration stage, which presents its iteration counter as the address.
- Output is registered: one clock, asynchronous active-low reset.

Parameters:
- ADDR_W, 5, address width; table depth is 2^ADDR_W = 32 entries. Fixed; other values unsupported.
- DATA_W, 32, width of each table entry.
- FRAC_BITS, 30, fractional bits of the angle format: unsigned Q2.30, radians.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- address  input  5  iteration index i.
- data  output  32  registered atan(2^-i) in Q2.30.

Behaviour:
- Entry value: entry[i] = floor(atan(2^-i) * 2^30), truncated toward zero, unsigned.
- Required constants, i = 0..9:
  - 0: 0x3243F6A8
  - 1: 0x1DAC6705
  - 2: 0x0FADBAFC
  - 3: 0x07F56EA6
  - 4: 0x03FEAB76
  - 5: 0x01FFD55B
  - 6: 0x00FFFAAA
  - 7: 0x007FFF55
  - 8: 0x003FFFEA
  - 9: 0x001FFFFD
- i = 10..29: entry[i] = 2^(30-i) - 1, e.g. 10: 0x000FFFFF, 11: 0x0007FFFF, 29: 0x00000001.
- i = 30 and i = 31: entry = 0x00000000, because the value truncates below 1 LSB.
- Latency: data reflects the address sampled at the previous rising edge (1 cycle). There is no combinational path from address to data.
- Reset: while rst_n = 0, data = 0x00000000 immediately, without waiting for a clock edge. On the first rising edge after rst_n deasserts, data loads entry[address].
- Reset asserted mid-operation: data is forced to 0 at once; the table contents are unaffected (constant).
- Address held constant: data is stable from the second edge onward.
- Address changing every cycle: each cycle's data matches the prior cycle's address, with no bubbles.
- The address space is fully decoded, so there is no out-of-range case and no X on data for any defined address.
- Address containing X/Z: data is don't-care, but it must not corrupt later lookups.
- Table is synthesisable as LUT/ROM. No write port and no initialisation file; constants are elaborated from the shared package.

Decomposition:
- Shared package cordic_pkg holds:
  - ADDR_W, DATA_W and FRAC_BITS constants;
  - the angle typedef (32-bit unsigned Q2.30);
  - the 32-entry ATAN_TABLE constant array, also used by the bench's reference model.
- No sub-module: a single module containing the constant array indexed by address and one output register.

Test Plan:
- Reset: hold rst_n = 0 with address = 0 and clocks running -> data = 0x00000000. Assert rst_n low asynchronously mid-cycle -> data goes to 0 before the next edge.
- Full sweep: after reset, apply address = 0..31, one per cycle -> each data equals ATAN_TABLE[address] one cycle later, e.g. 0 -> 0x3243F6A8, 1 -> 0x1DAC6705, 4 -> 0x03FEAB76, 10 -> 0x000FFFFF.
- Tail boundary: address = 29, 30, 31 -> 0x00000001, 0x00000000, 0x00000000.
- Latency check: change address 0 -> 3 between edges -> data still 0x3243F6A8 until the next rising edge, then 0x07F56EA6.
- Back-to-back random addresses for 1000 cycles -> data matches the 1-cycle-delayed table model with no mismatches.
- Reset mid-sweep: rst_n low at address = 5 -> data = 0. Release with address = 5 -> 0x01FFD55B on the following edge.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC datapath: angle format and the
// arctangent table atan(2^-i), i = 0..31, in unsigned Q2.30 radians.
package cordic_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int FRAC_BITS = 30;
    localparam int DEPTH     = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] angle_t;

    // floor(atan(2^-i) * 2^30). From i = 10 the cubic term of the series
    // drops below 1 LSB, so entries collapse to 2^(30-i) - 1. Entries 30 and
    // 31 truncate to zero.
    localparam angle_t ATAN_TABLE [0:DEPTH-1] = '{
        32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
        32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
        32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
        32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF,
        32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
        32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F,
        32'h0000003F, 32'h0000001F, 32'h0000000F, 32'h00000007,
        32'h00000003, 32'h00000001, 32'h00000000, 32'h00000000
    };

endpackage

// File: rtl/cordic_atan_rom.sv
// Registered arctangent lookup for the CORDIC iteration stage. The iteration
// counter is the address; the angle appears one clock later.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data
);

    angle_t data_d;
    angle_t data_q;

    // Fully decoded constant table; every 5-bit address maps to an entry.
    always_comb begin
        data_d = ATAN_TABLE[address];
    end

    // Output register, cleared immediately while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: tb/tb_cordic_atan_rom.sv
// Scoreboard bench for cordic_atan_rom: the driver pushes the expected angle
// when it presents an address; the monitor pops and compares one edge later.
module tb_cordic_atan_rom;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  address = '0;
    logic [31:0] data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          addr;
        logic [31:0] exp;
    } item_t;

    item_t exp_q[$];

    cordic_atan_rom dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .address (address),
        .data    (data)
    );

    always #5 clk = ~clk;

    // Reference: listed constants for small i, closed form beyond.
    function automatic logic [31:0] ref_atan(input int i);
        logic [31:0] head [0:9];
        head = '{32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
                 32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
                 32'h003FFFEA, 32'h001FFFFD};
        if (i < 10)      return head[i];
        else if (i < 30) return (32'd1 << (30 - i)) - 32'd1;
        else             return 32'd0;
    endfunction

    task automatic chk(input string name, input int addr,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s addr=%0d got=%08h expected=%08h", name, addr, act, exp);
        end
    endtask

    task automatic drive(input int a);
        @(negedge clk);
        address = 5'(a);
        exp_q.push_back('{a, ref_atan(a)});
    endtask

    // Monitor: data after each edge reflects the address presented before it.
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            item_t it;
            it = exp_q.pop_front();
            chk("lookup", it.addr, data, it.exp);
        end
    end

    initial begin
        // Reset held with clocks running.
        rst_n   = 1'b0;
        address = 5'd0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", 0, data, 32'h0);
        end
        rst_n = 1'b1;

        // Full sweep, one address per cycle.
        for (int i = 0; i < 32; i++) drive(i);

        // Tail boundary.
        drive(29); drive(30); drive(31);

        // Latency: address changes between edges, data must not follow.
        drive(0);
        drive(3);
        #1;
        chk("latency_hold", 3, data, 32'h3243F6A8);

        // Back-to-back random addresses.
        for (int n = 0; n < 1000; n++) drive(int'($urandom_range(0, 31)));

        // Reset mid-sweep at address 5.
        for (int i = 0; i <= 5; i++) drive(i);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset", 5, data, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("reset_mid", 5, data, 32'h0);
        end
        @(negedge clk);
        address = 5'd5;
        rst_n   = 1'b1;
        #1;
        chk("release_no_edge", 5, data, 32'h0);
        exp_q.push_back('{5, ref_atan(5)});

        // Held address: stable from the second edge on.
        drive(7); drive(7); drive(7);

        // Drain with a bounded wait.
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
